// File: rtl/alu_logic_pkg.sv
// Shared function codes for the configurable bitwise logic unit.
// Bit n of a function code is the result bit for {RHS[i], LHS[i]} == n.
package alu_logic_pkg;

  localparam logic [3:0] FN_ZERO     = 4'b0000;
  localparam logic [3:0] FN_AND      = 4'b1000;
  localparam logic [3:0] FN_OR       = 4'b1110;
  localparam logic [3:0] FN_XOR      = 4'b0110;
  localparam logic [3:0] FN_PASS_RHS = 4'b1100;
  localparam logic [3:0] FN_NOT_RHS  = 4'b0011;
  localparam logic [3:0] FN_PASS_LHS = 4'b1010;
  localparam logic [3:0] FN_ONES     = 4'b1111;
  localparam logic [3:0] FN_RESET    = FN_PASS_RHS;

endpackage

// File: rtl/alu_logic_stage.sv
// One pipeline register of the logic unit: valid bit, result data and three result flags.
// Data and flags load only under an incoming valid, so bubbles leave the last result visible.
module alu_logic_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             zero_i,
  input  logic             all_ones_i,
  input  logic             parity_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             all_ones_o,
  output logic             parity_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic             zero_d, zero_q;
  logic             all_ones_d, all_ones_q;
  logic             parity_d, parity_q;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    zero_d     = zero_q;
    all_ones_d = all_ones_q;
    parity_d   = parity_q;
    if (!stall_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d     = data_i;
        zero_d     = zero_i;
        all_ones_d = all_ones_i;
        parity_d   = parity_i;
      end
    end
  end

  // Reset values describe an all-zero result, hence zero flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      zero_q     <= 1'b1;
      all_ones_q <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      zero_q     <= zero_d;
      all_ones_q <= all_ones_d;
      parity_q   <= parity_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign zero_o     = zero_q;
  assign all_ones_o = all_ones_q;
  assign parity_o   = parity_q;

endmodule

// File: rtl/alu_logic_pipe.sv
// Configurable bitwise logic unit: per-bit truth-table lookup from a latched function register,
// followed by a stallable valid pipeline of LATENCY stages carrying result and flags.
module alu_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             AluClock,
  input  logic             Reset,
  input  logic             FuncWe,
  input  logic [3:0]       FuncIn,
  input  logic             InValid,
  input  logic             Stall,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  output logic [WIDTH-1:0] Logic,
  output logic             OutValid,
  output logic             Zero,
  output logic             AllOnes,
  output logic             Parity,
  output logic [3:0]       FuncCur
);

  logic [3:0] func_d, func_q;

  always_comb begin
    func_d = func_q;
    if (FuncWe) func_d = FuncIn;
  end

  always_ff @(posedge AluClock) begin
    if (Reset) func_q <= FN_RESET;
    else       func_q <= func_d;
  end

  // Ops sampled on a FuncWe edge still see func_q, i.e. the previous function.
  logic [WIDTH-1:0] result;

  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      result[i] = func_q[{RHS[i], LHS[i]}];
    end
  end

  // Index 0 is the combinational input side; index LATENCY drives the outputs.
  logic             valid_s    [LATENCY+1];
  logic [WIDTH-1:0] data_s     [LATENCY+1];
  logic             zero_s     [LATENCY+1];
  logic             all_ones_s [LATENCY+1];
  logic             parity_s   [LATENCY+1];

  assign valid_s[0]    = InValid;
  assign data_s[0]     = result;
  assign zero_s[0]     = ~|result;
  assign all_ones_s[0] = &result;
  assign parity_s[0]   = ^result;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    alu_logic_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i     (AluClock),
      .rst_i     (Reset),
      .stall_i   (Stall),
      .valid_i   (valid_s[k]),
      .data_i    (data_s[k]),
      .zero_i    (zero_s[k]),
      .all_ones_i(all_ones_s[k]),
      .parity_i  (parity_s[k]),
      .valid_o   (valid_s[k+1]),
      .data_o    (data_s[k+1]),
      .zero_o    (zero_s[k+1]),
      .all_ones_o(all_ones_s[k+1]),
      .parity_o  (parity_s[k+1])
    );
  end

  assign Logic    = data_s[LATENCY];
  assign OutValid = valid_s[LATENCY];
  assign Zero     = zero_s[LATENCY];
  assign AllOnes  = all_ones_s[LATENCY];
  assign Parity   = parity_s[LATENCY];
  assign FuncCur  = func_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Bench for alu_logic_pipe: an 8-bit/1-stage and a 16-bit/3-stage instance share stimulus and
// are compared every cycle against an op-history model, plus directed literal checks.
module tb_alu_logic_pipe;
  import alu_logic_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  fin;
  logic        inv;
  logic        stall;
  logic [15:0] lhs;
  logic [15:0] rhs;

  logic [7:0]  lg8;
  logic        ov8, z8, a8, p8;
  logic [3:0]  fc8;
  logic [15:0] lg16;
  logic        ov16, z16, a16, p16;
  logic [3:0]  fc16;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  alu_logic_pipe #(
    .WIDTH  (8),
    .LATENCY(1)
  ) dut8 (
    .AluClock(clk),
    .Reset   (rst),
    .FuncWe  (we),
    .FuncIn  (fin),
    .InValid (inv),
    .Stall   (stall),
    .LHS     (lhs[7:0]),
    .RHS     (rhs[7:0]),
    .Logic   (lg8),
    .OutValid(ov8),
    .Zero    (z8),
    .AllOnes (a8),
    .Parity  (p8),
    .FuncCur (fc8)
  );

  alu_logic_pipe #(
    .WIDTH  (16),
    .LATENCY(3)
  ) dut16 (
    .AluClock(clk),
    .Reset   (rst),
    .FuncWe  (we),
    .FuncIn  (fin),
    .InValid (inv),
    .Stall   (stall),
    .LHS     (lhs),
    .RHS     (rhs),
    .Logic   (lg16),
    .OutValid(ov16),
    .Zero    (z16),
    .AllOnes (a16),
    .Parity  (p16),
    .FuncCur (fc16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each unstalled edge pushes one {valid, result} entry into a history of the last
  // three accepted slots; an instance shows the entry LATENCY slots back and the last valid
  // result that ever reached that position.
  typedef struct {
    bit          v;
    logic [15:0] d;
  } item_t;

  item_t       hist [3];
  int          cnt;
  logic [3:0]  m_func;
  logic [15:0] m_out [2];
  int          lat [2] = '{1, 3};

  function automatic logic [15:0] lut(input logic [3:0] f, input logic [15:0] l,
                                      input logic [15:0] r);
    logic [15:0] res;
    for (int i = 0; i < 16; i++) res[i] = f[{r[i], l[i]}];
    return res;
  endfunction

  function automatic bit m_valid(input int k);
    return (cnt >= lat[k]) && hist[lat[k]-1].v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_func   = FN_RESET;
        cnt      = 0;
        m_out[0] = '0;
        m_out[1] = '0;
        started  = 1;
      end else begin
        if (!stall) begin
          hist[2] = hist[1];
          hist[1] = hist[0];
          hist[0].v = inv;
          hist[0].d = lut(m_func, lhs, rhs);
          if (cnt < 3) cnt++;
          for (int k = 0; k < 2; k++) begin
            if (m_valid(k)) m_out[k] = hist[lat[k]-1].d;
          end
        end
        if (we) m_func = fin;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("ov8", 32'(ov8), 32'(m_valid(0)));
        chk("logic8", 32'(lg8), 32'(m_out[0][7:0]));
        chk("zero8", 32'(z8), 32'(m_out[0][7:0] == 8'h00));
        chk("allones8", 32'(a8), 32'(m_out[0][7:0] == 8'hFF));
        chk("parity8", 32'(p8), 32'(^m_out[0][7:0]));
        chk("func8", 32'(fc8), 32'(m_func));
        chk("ov16", 32'(ov16), 32'(m_valid(1)));
        chk("logic16", 32'(lg16), 32'(m_out[1]));
        chk("zero16", 32'(z16), 32'(m_out[1] == 16'h0000));
        chk("allones16", 32'(a16), 32'(m_out[1] == 16'hFFFF));
        chk("parity16", 32'(p16), 32'(^m_out[1]));
        chk("func16", 32'(fc16), 32'(m_func));
      end
    end
  end

  task automatic step(input logic w, input logic [3:0] f, input logic v, input logic [15:0] l,
                      input logic [15:0] r, input logic s);
    we    = w;
    fin   = f;
    inv   = v;
    lhs   = l;
    rhs   = r;
    stall = s;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fns  [6] = '{FN_AND, FN_OR, FN_XOR, FN_NOT_RHS, FN_ZERO, FN_ONES};
  logic [7:0] exps [6] = '{8'h30, 8'hFC, 8'hCC, 8'hC3, 8'h00, 8'hFF};

  initial begin
    rst = 1'b1;
    we = 1'b0; fin = '0; inv = 1'b0; stall = 1'b0; lhs = '0; rhs = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov8", 32'(ov8), 0);
    chk("rst_zero8", 32'(z8), 1);
    chk("rst_func8", 32'(fc8), 32'hC);
    rst = 1'b0;

    // Default function passes RHS.
    step(1'b0, 4'h0, 1'b1, 16'h00F0, 16'h003C, 1'b0);
    chk("t1_logic", 32'(lg8), 32'h3C);
    chk("t1_ov", 32'(ov8), 1);
    chk("t1_flags", 32'({z8, a8, p8}), 0);

    foreach (fns[i]) begin
      step(1'b1, fns[i], 1'b0, 16'h0, 16'h0, 1'b0);
      step(1'b0, 4'h0, 1'b1, 16'h00F0, 16'h003C, 1'b0);
      chk("t2_logic", 32'(lg8), 32'(exps[i]));
      chk("t2_zero", 32'(z8), 32'(exps[i] == 8'h00));
      chk("t2_allones", 32'(a8), 32'(exps[i] == 8'hFF));
    end
    chk("t2_parity_ff", 32'(p8), 0);

    step(1'b1, FN_PASS_RHS, 1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b1, FN_XOR, 1'b1, 16'h00AA, 16'h0055, 1'b0);
    chk("t3_old_func", 32'(lg8), 32'h55);
    step(1'b0, 4'h0, 1'b1, 16'h00AA, 16'h0055, 1'b0);
    chk("t3_new_func", 32'(lg8), 32'hFF);
    chk("t3_funccur", 32'(fc8), 32'(FN_XOR));

    // Three-stage instance: A, B, two stalled edges, C.
    repeat (3) step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 16'h0, 16'h1111, 1'b0);
    step(1'b0, 4'h0, 1'b1, 16'h0, 16'h2222, 1'b0);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1);
    chk("t4_stall1_ov", 32'(ov16), 0);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1);
    chk("t4_stall2_ov", 32'(ov16), 0);
    step(1'b0, 4'h0, 1'b1, 16'h0, 16'h3333, 1'b0);
    chk("t4_a", 32'({ov16, lg16}), 32'h11111);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("t4_b", 32'({ov16, lg16}), 32'h12222);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("t4_c", 32'({ov16, lg16}), 32'h13333);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("t4_bubble", 32'({ov16, lg16}), 32'h03333);

    // Reset with two ops in flight.
    step(1'b0, 4'h0, 1'b1, 16'h0, 16'h4444, 1'b0);
    step(1'b0, 4'h0, 1'b1, 16'h0, 16'h5555, 1'b0);
    rst = 1'b1;
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("t5_ov", 32'(ov16), 0);
    chk("t5_logic", 32'(lg16), 0);
    chk("t5_func", 32'(fc16), 32'hC);
    chk("t5_zero", 32'(z16), 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("t5_no_emerge", 32'(ov16), 0);
    end

    step(1'b1, FN_OR, 1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 16'h8001, 16'h0100, 1'b0);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("t6_logic", 32'({ov16, lg16}), 32'h18101);
    chk("t6_parity", 32'(p16), 1);
    step(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("t6_bubble", 32'({ov16, lg16}), 32'h08101);

    for (int i = 0; i < 3000; i++) begin
      logic s;
      rst = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 7) == 0), 4'($urandom), s ? 1'b0 : 1'($urandom),
           16'($urandom), 16'($urandom), s);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
